// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding and parity mode constants shared by the UART transmitter.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
    localparam logic [2:0] ST_PARITY = PARITY;
    localparam logic [2:0] ST_STOP   = STOP;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;
endpackage

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: request/serial-line bundle between a client (master) and the transmitter (slave).
interface uart_tx_param_if #(parameter int DATA_W = 8) ();
    logic              send_data;
    logic [DATA_W-1:0] data_in;
    logic              send_ready;
    logic              tx;
    logic              tx_done;
    logic              busy;
    modport master (output send_data, data_in, input send_ready, tx, tx_done, busy);
    modport slave (input send_data, data_in, output send_ready, tx, tx_done, busy);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-time counter; tick marks the last clk cycle of each bit while enabled.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    logic [CW-1:0] r_cnt;
    assign tick = enable && (r_cnt == LAST);
    always_ff @(posedge clk) begin
        if (reset || !enable || tick) r_cnt <= '0;
        else r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter (start, DATA_W LSB-first bits, optional parity, 1-2 stop bits).
module uart_tx_param import uart_pkg::*; #(
    parameter int DATA_W       = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16
) (
    input logic            clk,
    input logic            reset,
    uart_tx_param_if.slave bus
);
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_param: DATA_W must be 5..9");
    end
    if (PARITY_MODE != PARITY_NONE && PARITY_MODE != PARITY_EVEN && PARITY_MODE != PARITY_ODD) begin : g_bad_parity
        $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_param: CLKS_PER_BIT must be at least 2");
    end
    localparam int BW = $clog2(DATA_W + 1);
    logic [2:0]        r_state;
    logic [DATA_W-1:0] r_shift;
    logic [BW-1:0]     r_bit_cnt;
    logic              r_stop_cnt;
    logic              r_parity;
    logic              r_tx;
    logic              w_run;
    logic              w_tick;
    logic              w_accept;
    logic              w_last_stop;
    assign w_run          = r_state != ST_IDLE;
    assign w_accept       = !w_run && bus.send_data;
    assign w_last_stop    = r_stop_cnt == 1'(STOP_BITS - 1);
    assign bus.send_ready = !w_run;
    assign bus.busy       = w_run;
    assign bus.tx         = r_tx;
    assign bus.tx_done    = (r_state == ST_STOP) && w_tick && w_last_stop;
    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (w_run),
        .tick   (w_tick)
    );
    // r_tx is loaded with the level of the bit being entered, so the line changes exactly on bit boundaries
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tx       <= 1'b1;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_parity   <= 1'b0;
        end else if (w_accept) begin
            r_state  <= ST_START;
            r_tx     <= 1'b0;
            r_shift  <= bus.data_in;
            r_parity <= ^bus.data_in ^ 1'(PARITY_MODE == PARITY_ODD);
        end else if (w_tick) begin
            case (r_state)
                ST_START: begin
                    r_state   <= ST_DATA;
                    r_tx      <= r_shift[0];
                    r_shift   <= r_shift >> 1;
                    r_bit_cnt <= '0;
                end
                ST_DATA: begin
                    if (r_bit_cnt == BW'(DATA_W - 1)) begin
                        r_state    <= (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
                        r_tx       <= (PARITY_MODE == PARITY_NONE) ? 1'b1 : r_parity;
                        r_stop_cnt <= 1'b0;
                    end else begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    r_state    <= ST_STOP;
                    r_tx       <= 1'b1;
                    r_stop_cnt <= 1'b0;
                end
                ST_STOP: begin
                    if (w_last_stop) r_state <= ST_IDLE;
                    else r_stop_cnt <= r_stop_cnt + 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed checks of framing, parity, stop bits, busy-ignore, reset abort and back-to-back frames.
module tb_uart_tx_param;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sd [5];
    logic [8:0] din [5];
    logic [4:0] tx_o, done_o, rdy_o, busy_o;
    logic [63:0] txs, dns, rds, bss;
    int n_cmp = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    uart_tx_param_if #(.DATA_W(8)) if0 ();
    uart_tx_param_if #(.DATA_W(8)) if1 ();
    uart_tx_param_if #(.DATA_W(8)) if2 ();
    uart_tx_param_if #(.DATA_W(8)) if3 ();
    uart_tx_param_if #(.DATA_W(5)) if4 ();
    assign if0.send_data = sd[0];
    assign if1.send_data = sd[1];
    assign if2.send_data = sd[2];
    assign if3.send_data = sd[3];
    assign if4.send_data = sd[4];
    assign if0.data_in = din[0][7:0];
    assign if1.data_in = din[1][7:0];
    assign if2.data_in = din[2][7:0];
    assign if3.data_in = din[3][7:0];
    assign if4.data_in = din[4][4:0];
    assign tx_o   = {if4.tx, if3.tx, if2.tx, if1.tx, if0.tx};
    assign done_o = {if4.tx_done, if3.tx_done, if2.tx_done, if1.tx_done, if0.tx_done};
    assign rdy_o  = {if4.send_ready, if3.send_ready, if2.send_ready, if1.send_ready, if0.send_ready};
    assign busy_o = {if4.busy, if3.busy, if2.busy, if1.busy, if0.busy};
    uart_tx_param #(.DATA_W(8), .PARITY_MODE(0), .STOP_BITS(1), .CLKS_PER_BIT(4)) dut0 (.clk(clk), .reset(rst), .bus(if0));
    uart_tx_param #(.DATA_W(8), .PARITY_MODE(1), .STOP_BITS(1), .CLKS_PER_BIT(4)) dut1 (.clk(clk), .reset(rst), .bus(if1));
    uart_tx_param #(.DATA_W(8), .PARITY_MODE(2), .STOP_BITS(1), .CLKS_PER_BIT(4)) dut2 (.clk(clk), .reset(rst), .bus(if2));
    uart_tx_param #(.DATA_W(8), .PARITY_MODE(0), .STOP_BITS(2), .CLKS_PER_BIT(4)) dut3 (.clk(clk), .reset(rst), .bus(if3));
    uart_tx_param #(.DATA_W(5), .PARITY_MODE(0), .STOP_BITS(1), .CLKS_PER_BIT(2)) dut4 (.clk(clk), .reset(rst), .bus(if4));
    // bit k of the returned vector is the expected tx level in cycle k after acceptance
    function automatic logic [63:0] wave(input logic [15:0] bits, input int nb, input int c);
        logic [63:0] w = '0;
        for (int b = 0; b < nb; b++)
            for (int j = 0; j < c; j++) w[1 + b * c + j] = bits[b];
        return w;
    endfunction
    function automatic logic [63:0] win(input logic [63:0] v, input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return v & m;
    endfunction
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    // request a frame on instance s, then record n cycles; optional extra pulse at cycle pk and reset at cycle rk
    task automatic run(input int s, input logic [8:0] d, input int n, input bit hold,
                       input int pk, input logic [8:0] pd, input int rk);
        txs = '0; dns = '0; rds = '0; bss = '0;
        @(negedge clk);
        sd[s] = 1'b1;
        din[s] = d;
        @(posedge clk);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) sd[s] = 1'b0;
            if (k == pk) begin sd[s] = 1'b1; din[s] = pd; end
            if (k == pk + 1) sd[s] = 1'b0;
            if (k == rk) rst = 1'b1;
            if (k == rk + 1) rst = 1'b0;
            txs[k] = tx_o[s];
            dns[k] = done_o[s];
            rds[k] = rdy_o[s];
            bss[k] = busy_o[s];
        end
    endtask
    logic [63:0] f5;
    initial begin
        for (int i = 0; i < 5; i++) begin sd[i] = 1'b0; din[i] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++)
            chk($sformatf("reset_idle%0d", i), {60'd0, tx_o[i], rdy_o[i], busy_o[i], done_o[i]}, 64'hC);
        run(0, 9'h055, 44, 1'b0, -9, 9'h0, -9);
        chk("none_55_tx", win(txs, 1, 40), wave(16'b1010101010, 10, 4));
        chk("none_55_done", win(dns, 1, 44), 64'd1 << 40);
        chk("none_55_ready", win(rds, 1, 44), 64'hF << 41);
        chk("none_55_busy", win(bss, 1, 44), win('1, 1, 40));
        chk("none_55_idle_tx", win(txs, 41, 44), 64'hF << 41);
        run(1, 9'h007, 46, 1'b0, -9, 9'h0, -9);
        chk("even_07_tx", win(txs, 1, 44), wave(16'b11000001110, 11, 4));
        chk("even_07_par", win(txs, 37, 40), 64'hF << 37);
        chk("even_07_done", win(dns, 1, 46), 64'd1 << 44);
        chk("even_07_ready", win(rds, 1, 46), 64'h3 << 45);
        run(2, 9'h007, 46, 1'b0, -9, 9'h0, -9);
        chk("odd_07_tx", win(txs, 1, 44), wave(16'b10000001110, 11, 4));
        chk("odd_07_par", win(txs, 37, 40), 64'd0);
        chk("odd_07_done", win(dns, 1, 46), 64'd1 << 44);
        run(3, 9'h000, 46, 1'b0, -9, 9'h0, -9);
        chk("stop2_00_tx", win(txs, 1, 44), wave(16'b11000000000, 11, 4));
        chk("stop2_00_lastdata", win(txs, 33, 36), 64'd0);
        chk("stop2_00_high", win(txs, 37, 44), 64'hFF << 37);
        chk("stop2_00_done", win(dns, 1, 46), 64'd1 << 44);
        run(0, 9'h00F, 60, 1'b0, 10, 9'h0AA, -9);
        chk("busy_ign_tx", win(txs, 1, 40), wave(16'b1000011110, 10, 4));
        chk("busy_ign_idle_tx", win(txs, 41, 60), win('1, 41, 60));
        chk("busy_ign_done", win(dns, 1, 60), 64'd1 << 40);
        chk("busy_ign_ready", win(rds, 41, 60), win('1, 41, 60));
        run(0, 9'h000, 30, 1'b0, -9, 9'h0, 14);
        chk("abort_pre_tx", win(txs, 1, 14), 64'd0);
        chk("abort_after", {60'd0, txs[15], rds[15], bss[15], dns[15]}, 64'hC);
        chk("abort_no_done", win(dns, 1, 30), 64'd0);
        chk("abort_idle_tx", win(txs, 15, 30), win('1, 15, 30));
        run(0, 9'h03C, 44, 1'b0, -9, 9'h0, -9);
        chk("after_abort_3c_tx", win(txs, 1, 40), wave(16'b1001111000, 10, 4));
        chk("after_abort_3c_done", win(dns, 1, 44), 64'd1 << 40);
        f5 = wave(16'b1101010, 7, 2);
        run(4, 9'h015, 44, 1'b1, -9, 9'h0, -9);
        sd[4] = 1'b0;
        chk("b2b_tx", win(txs, 1, 44), win(f5 | (64'd1 << 15) | (f5 << 15) | (64'd1 << 30) | (f5 << 30), 1, 44));
        chk("b2b_done", win(dns, 1, 44), (64'd1 << 14) | (64'd1 << 29) | (64'd1 << 44));
        chk("b2b_ready", win(rds, 1, 44), (64'd1 << 15) | (64'd1 << 30));
        repeat (40) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
